// File: rtl/ahb3lite_sram_slave.sv
// ahb3lite_sram_slave: AHB3-Lite word SRAM slave with programmable wait states and two-cycle ERROR response
module ahb3lite_sram_slave #(
    parameter int MEM_WORDS   = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [15:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);
    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;
    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          pend_q, pend_d, write_q, write_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [2:0]    size_q, size_d;
    logic [31:0]   mem [MEM_WORDS];
    logic          accept, err, done;
    logic [3:0]    be;
    logic          unused;
    assign unused = ^{HBURST, HPROT, HTRANS[0]};
    assign accept = HSEL && HTRANS[1] && HREADY && (state_q == IDLE || state_q == ERR2);
    assign err = ({1'b0, HADDR} >= 17'(MEM_WORDS * 4)) || (HSIZE > 3'b010)
               || (HSIZE == 3'b001 && HADDR[0]) || (HSIZE == 3'b010 && HADDR[1:0] != 2'b00);
    // pend_q in IDLE marks the completion (data-phase) cycle of a good transfer
    assign done = state_q == IDLE && pend_q;
    assign be = size_q == 3'd0 ? 4'b0001 << addr_q[1:0]
              : size_q == 3'd1 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign HREADYOUT = !(state_q == WAIT || state_q == ERR1);
    assign HRESP = state_q == ERR1 || state_q == ERR2;
    assign HRDATA = (done && !write_q) ? mem[addr_q[AW+1:2]] : '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        addr_d  = addr_q;
        size_d  = size_q;
        write_d = write_q;
        case (state_q)
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end
            end
            ERR1: state_d = ERR2;
            default: begin
                state_d = IDLE;
                pend_d  = 1'b0;
                if (accept) begin
                    addr_d  = HADDR[AW+1:0];
                    size_d  = HSIZE;
                    write_d = HWRITE;
                    if (err) state_d = ERR1;
                    else begin
                        pend_d = 1'b1;
                        if (WAIT_STATES > 0) begin
                            state_d = WAIT;
                            cnt_d   = 4'(WAIT_STATES);
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            write_q <= write_d;
        end
    end

    always_ff @(posedge HCLK) begin
        if (done && write_q)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[addr_q[AW+1:2]][8*i +: 8] <= HWDATA[8*i +: 8];
    end
endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// tb_ahb3lite_sram_slave: directed checks of the SRAM slave with 1 and 0 wait states
module tb_ahb3lite_sram_slave;
    logic        hclk = 1'b0, hreset = 1'b1, sel_a = 1'b0, sel_b = 1'b0, hwrite = 1'b0;
    logic [15:0] haddr = '0;
    logic [1:0]  htrans = '0;
    logic [2:0]  hsize = '0;
    logic [31:0] hwdata = '0;
    logic [31:0] rdata_a, rdata_b;
    logic        ro_a, ro_b, resp_a, resp_b;
    int          errors = 0, checks = 0, waits;
    logic        rw, rc;
    logic [31:0] rd;

    always #5 hclk = ~hclk;

    ahb3lite_sram_slave #(.MEM_WORDS(256), .WAIT_STATES(1)) dut_a (
        .HCLK(hclk), .HRESET(hreset), .HSEL(sel_a), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b000), .HPROT(4'b0000), .HWDATA(hwdata),
        .HREADY(ro_a), .HRDATA(rdata_a), .HREADYOUT(ro_a), .HRESP(resp_a));

    ahb3lite_sram_slave #(.MEM_WORDS(256), .WAIT_STATES(0)) dut_b (
        .HCLK(hclk), .HRESET(hreset), .HSEL(sel_b), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b000), .HPROT(4'b0000), .HWDATA(hwdata),
        .HREADY(ro_b), .HRDATA(rdata_b), .HREADYOUT(ro_b), .HRESP(resp_b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // one non-pipelined transfer on dut_a; returns at the negedge of its completion cycle
    task automatic xfer(input logic w, input logic [2:0] sz, input logic [15:0] a,
                        input logic [31:0] wd, output int nw, output logic r_w,
                        output logic r_c, output logic [31:0] r_d);
        @(posedge hclk); #1;
        sel_a = 1'b1; htrans = 2'b10; hwrite = w; hsize = sz; haddr = a;
        @(posedge hclk); #1;
        sel_a = 1'b0; htrans = 2'b00; hwdata = wd;
        nw = 0;
        r_w = 1'b0;
        @(negedge hclk);
        while (!ro_a && nw < 20) begin
            nw++;
            r_w = resp_a;
            @(posedge hclk);
            @(negedge hclk);
        end
        r_c = resp_a;
        r_d = rdata_a;
    endtask

    initial begin
        @(negedge hclk);
        chk("rst_ready", 32'(ro_a), 32'd1);
        chk("rst_resp", 32'(resp_a), 32'd0);
        chk("rst_rdata", rdata_a, 32'h0);
        @(posedge hclk); #1;
        hreset = 1'b0;

        xfer(1'b1, 3'd2, 16'h0010, 32'hDEADBEEF, waits, rw, rc, rd);
        chk("wr_waits", waits, 32'd1);
        chk("wr_resp_wait", 32'(rw), 32'd0);
        chk("wr_resp_done", 32'(rc), 32'd0);
        xfer(1'b0, 3'd2, 16'h0010, 32'h0, waits, rw, rc, rd);
        chk("rd_waits", waits, 32'd1);
        chk("rd_deadbeef", rd, 32'hDEADBEEF);
        @(posedge hclk); @(negedge hclk);
        chk("idle_rdata", rdata_a, 32'h0);

        xfer(1'b1, 3'd2, 16'h0010, 32'h11223344, waits, rw, rc, rd);
        xfer(1'b1, 3'd0, 16'h0013, 32'hAA5A5A5A, waits, rw, rc, rd);
        xfer(1'b0, 3'd2, 16'h0010, 32'h0, waits, rw, rc, rd);
        chk("byte_lane3", rd, 32'hAA223344);
        xfer(1'b1, 3'd1, 16'h0012, 32'hBEEF1234, waits, rw, rc, rd);
        xfer(1'b0, 3'd2, 16'h0010, 32'h0, waits, rw, rc, rd);
        chk("half_upper", rd, 32'hBEEF3344);

        xfer(1'b0, 3'd2, 16'h0002, 32'h0, waits, rw, rc, rd);
        chk("mis_waits", waits, 32'd1);
        chk("mis_resp1", 32'(rw), 32'd1);
        chk("mis_resp2", 32'(rc), 32'd1);
        chk("mis_rdata", rd, 32'h0);

        xfer(1'b1, 3'd2, 16'h0000, 32'h01020304, waits, rw, rc, rd);
        xfer(1'b1, 3'd2, 16'h0400, 32'hFFFFFFFF, waits, rw, rc, rd);
        chk("oob_resp1", 32'(rw), 32'd1);
        chk("oob_resp2", 32'(rc), 32'd1);
        xfer(1'b1, 3'd1, 16'h0001, 32'hFFFFFFFF, waits, rw, rc, rd);
        chk("odd_half_resp", 32'(rc), 32'd1);
        xfer(1'b1, 3'd3, 16'h0000, 32'hFFFFFFFF, waits, rw, rc, rd);
        chk("bad_size_resp", 32'(rc), 32'd1);
        xfer(1'b0, 3'd2, 16'h0000, 32'h0, waits, rw, rc, rd);
        chk("err_no_write", rd, 32'h01020304);
        chk("ok_after_err", 32'(rc), 32'd0);

        // pipelined pair on dut_a, with an address phase presented during the wait cycle
        xfer(1'b1, 3'd2, 16'h0034, 32'h34343434, waits, rw, rc, rd);
        @(posedge hclk); #1;
        sel_a = 1'b1; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2; haddr = 16'h0030;
        @(posedge hclk); #1;
        hwdata = 32'h0A0B0C0D; haddr = 16'h0034;
        @(negedge hclk);
        chk("pipe_wait", 32'(ro_a), 32'd0);
        @(posedge hclk); #1;
        hwrite = 1'b0; haddr = 16'h0030;
        @(negedge hclk);
        chk("pipe_wr_done", 32'(ro_a), 32'd1);
        @(posedge hclk); #1;
        sel_a = 1'b0; htrans = 2'b00;
        @(negedge hclk);
        chk("pipe_rd_wait", 32'(ro_a), 32'd0);
        chk("pipe_rd_wait_data", rdata_a, 32'h0);
        @(posedge hclk); @(negedge hclk);
        chk("pipe_rd_data", rdata_a, 32'h0A0B0C0D);
        xfer(1'b0, 3'd2, 16'h0034, 32'h0, waits, rw, rc, rd);
        chk("ignored_in_wait", rd, 32'h34343434);

        // zero wait states, back-to-back write then read on dut_b
        @(posedge hclk); #1;
        sel_b = 1'b1; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2; haddr = 16'h0020;
        @(posedge hclk); #1;
        hwdata = 32'h00000055; hwrite = 1'b0;
        @(negedge hclk);
        chk("ws0_wr_ready", 32'(ro_b), 32'd1);
        @(posedge hclk); #1;
        sel_b = 1'b0; htrans = 2'b00;
        @(negedge hclk);
        chk("ws0_rd_ready", 32'(ro_b), 32'd1);
        chk("ws0_rd_data", rdata_b, 32'h00000055);
        @(posedge hclk); @(negedge hclk);
        chk("ws0_idle_rdata", rdata_b, 32'h0);

        // reset during the wait cycle of a write aborts it
        xfer(1'b1, 3'd2, 16'h0020, 32'hCAFEF00D, waits, rw, rc, rd);
        @(posedge hclk); #1;
        sel_a = 1'b1; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2; haddr = 16'h0020;
        @(posedge hclk); #1;
        sel_a = 1'b0; htrans = 2'b00; hwdata = 32'h12345678;
        chk("pre_rst_wait", 32'(ro_a), 32'd0);
        #1 hreset = 1'b1;
        #1;
        chk("rst_async_ready", 32'(ro_a), 32'd1);
        chk("rst_async_resp", 32'(resp_a), 32'd0);
        @(posedge hclk); #1;
        hreset = 1'b0;
        xfer(1'b0, 3'd2, 16'h0020, 32'h0, waits, rw, rc, rd);
        chk("rst_abort_word", rd, 32'hCAFEF00D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
